// File: rtl/cfg_arb_pkg.sv
// Shared types for the configuration-register write arbiter.
package cfg_arb_pkg;

    localparam int CFG_ADDR_W = 6;
    localparam int CFG_DATA_W = 8;

    // Which requester owns the write port in a given cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SPI  = 2'd1,
        GNT_AUX  = 2'd2
    } gnt_e;

    // One buffered register write
    typedef struct packed {
        logic [CFG_ADDR_W-1:0] addr;
        logic [CFG_DATA_W-1:0] value;
    } cfg_entry_t;

endpackage

// File: rtl/cfg_wr_fifo.sv
// Small circular FIFO for SPI register writes. The level is kept as its own
// counter so DEPTH need not be a power of two.
module cfg_wr_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [3:0]   level,
    output logic [W-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop frees the head slot first, so a push into a full FIFO that pops
    // in the same cycle still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (level == 4'(DEPTH));
    assign empty = (level == 4'd0);
    assign head  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= 4'd0;
        end else begin
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            case ({do_push, do_pop})
                2'b10:   level <= level + 4'd1;
                2'b01:   level <= level - 4'd1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cfg_wr_arbiter.sv
// Shares the Configuration_Registers write port between the buffered SPI
// command stream and an auxiliary req/gnt requester, round-robin on ties.
module cfg_wr_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = CFG_ADDR_W,
    parameter int DATA_W = CFG_DATA_W
) (
    input  logic              SCK,
    input  logic              NRST,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_value,
    input  logic              spi_wr_en,
    input  logic              aux_req,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_value,
    output logic              aux_gnt,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_value,
    output logic              wr_en,
    output logic [3:0]        fifo_level,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic              busy
);

    localparam int EW = ADDR_W + DATA_W;

    gnt_e              sel;
    gnt_e              last_grant;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EW-1:0]     fifo_head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_value;
    logic              spi_pop;
    logic              spi_drop;

    cfg_wr_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (SCK),
        .rst_n (NRST),
        .push  (spi_wr_en),
        .pop   (spi_pop),
        .din   ({spi_addr, spi_value}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level),
        .head  (fifo_head)
    );

    assign head_addr  = fifo_head[DATA_W +: ADDR_W];
    assign head_value = fifo_head[DATA_W-1:0];

    assign spi_pop  = (sel == GNT_SPI);
    assign spi_drop = spi_wr_en && fifo_full && !spi_pop;
    assign busy     = !fifo_empty || (aux_req && !aux_gnt);

    // Pick this cycle's winner; on a tie the side not served last goes first
    always_comb begin
        sel = GNT_NONE;
        if (!fifo_empty && aux_req)
            sel = (last_grant == GNT_AUX) ? GNT_SPI : GNT_AUX;
        else if (!fifo_empty)
            sel = GNT_SPI;
        else if (aux_req)
            sel = GNT_AUX;
    end

    // Register the winning write, grant pulse, round-robin history and ovf
    always_ff @(posedge SCK or negedge NRST) begin
        if (!NRST) begin
            wr_en      <= 1'b0;
            aux_gnt    <= 1'b0;
            reg_addr   <= '0;
            reg_value  <= '0;
            last_grant <= GNT_AUX;
            ovf        <= 1'b0;
        end else begin
            wr_en   <= (sel != GNT_NONE);
            aux_gnt <= (sel == GNT_AUX);
            if (sel == GNT_SPI) begin
                reg_addr  <= head_addr;
                reg_value <= head_value;
            end else if (sel == GNT_AUX) begin
                reg_addr  <= aux_addr;
                reg_value <= aux_value;
            end
            if (sel != GNT_NONE) last_grant <= sel;
            // A fresh drop outranks a clear in the same cycle
            if (spi_drop)     ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cfg_wr_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts each committed
// write; a negedge monitor compares whatever the DUT presents.
module tb_cfg_wr_arbiter;
    import cfg_arb_pkg::*;

    localparam int DEPTH = 2;
    localparam int AW    = CFG_ADDR_W;
    localparam int DW    = CFG_DATA_W;

    logic          SCK = 1'b0;
    logic          NRST = 1'b1;
    logic [AW-1:0] spi_addr = '0;
    logic [DW-1:0] spi_value = '0;
    logic          spi_wr_en = 1'b0;
    logic          aux_req = 1'b0;
    logic [AW-1:0] aux_addr = '0;
    logic [DW-1:0] aux_value = '0;
    logic          aux_gnt;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_value;
    logic          wr_en;
    logic [3:0]    fifo_level;
    logic          ovf;
    logic          ovf_clr = 1'b0;
    logic          busy;

    cfg_wr_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .SCK        (SCK),
        .NRST       (NRST),
        .spi_addr   (spi_addr),
        .spi_value  (spi_value),
        .spi_wr_en  (spi_wr_en),
        .aux_req    (aux_req),
        .aux_addr   (aux_addr),
        .aux_value  (aux_value),
        .aux_gnt    (aux_gnt),
        .reg_addr   (reg_addr),
        .reg_value  (reg_value),
        .wr_en      (wr_en),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr),
        .busy       (busy)
    );

    always #5 SCK = ~SCK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: pending SPI writes, who was served last, sticky
    // overflow, and the last register write that was committed.
    typedef struct {
        bit         aux;
        cfg_entry_t e;
    } wr_t;

    cfg_entry_t mq[$];
    wr_t        exp_q[$];
    bit         m_last_aux = 1'b1;
    bit         m_ovf = 1'b0;
    bit         m_gnt_aux = 1'b0;
    cfg_entry_t m_reg = '0;

    // Model: at each edge serve one write (SPI entries must already be queued),
    // then append the new SPI write if there is room.
    initial begin : model
        int  win;
        wr_t w;
        bit  drop;
        forever begin
            @(posedge SCK or negedge NRST);
            if (!NRST) begin
                mq.delete();
                exp_q.delete();
                m_last_aux = 1'b1;
                m_ovf      = 1'b0;
                m_gnt_aux  = 1'b0;
                m_reg      = '0;
            end else begin
                if (mq.size() > 0 && aux_req) win = m_last_aux ? 1 : 2;
                else if (mq.size() > 0)       win = 1;
                else if (aux_req)             win = 2;
                else                          win = 0;
                if (win == 1) begin
                    w.aux = 1'b0;
                    w.e   = mq.pop_front();
                    exp_q.push_back(w);
                    m_reg      = w.e;
                    m_last_aux = 1'b0;
                end else if (win == 2) begin
                    w.aux = 1'b1;
                    w.e   = {aux_addr, aux_value};
                    exp_q.push_back(w);
                    m_reg      = w.e;
                    m_last_aux = 1'b1;
                end
                m_gnt_aux = (win == 2);
                drop = 1'b0;
                if (spi_wr_en) begin
                    if (mq.size() < DEPTH) mq.push_back({spi_addr, spi_value});
                    else drop = 1'b1;
                end
                if (drop)         m_ovf = 1'b1;
                else if (ovf_clr) m_ovf = 1'b0;
            end
        end
    end

    // Monitor: compare on the falling edge, away from the active edge
    initial begin : monitor
        wr_t w;
        forever begin
            @(negedge SCK);
            if (NRST) begin
                chk("fifo_level", fifo_level, mq.size());
                chk("ovf", ovf, m_ovf);
                chk("busy", busy, (mq.size() > 0) || (aux_req && !m_gnt_aux));
                if (wr_en) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_wr: wr_en=1 addr=%0h with no write expected at %0t", reg_addr, $time);
                    end else begin
                        w = exp_q.pop_front();
                        chk("sb_aux_gnt", aux_gnt, w.aux);
                        chk("sb_reg_addr", reg_addr, w.e.addr);
                        chk("sb_reg_value", reg_value, w.e.value);
                    end
                end else begin
                    if (exp_q.size() != 0) begin
                        checks++;
                        errors++;
                        $display("FAIL missing_wr: wr_en=0 but write %0h expected at %0t", exp_q[0].e, $time);
                        exp_q.delete();
                    end
                    chk("idle_aux_gnt", aux_gnt, 1'b0);
                    chk("hold_reg_addr", reg_addr, m_reg.addr);
                    chk("hold_reg_value", reg_value, m_reg.value);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge SCK);
        #1;
    endtask

    task automatic do_reset();
        NRST      = 1'b0;
        spi_wr_en = 1'b0;
        aux_req   = 1'b0;
        ovf_clr   = 1'b0;
        #1;
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_aux_gnt", aux_gnt, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_reg_value", reg_value, 0);
        chk("rst_fifo_level", fifo_level, 0);
        @(posedge SCK);
        #1;
        NRST = 1'b1;
    endtask

    task automatic spi_push(input logic [AW-1:0] a, input logic [DW-1:0] v);
        spi_wr_en = 1'b1;
        spi_addr  = a;
        spi_value = v;
    endtask

    task automatic drain();
        spi_wr_en = 1'b0;
        aux_req   = 1'b0;
        ovf_clr   = 1'b0;
        repeat (DEPTH + 3) cyc();
    endtask

    initial begin
        #2;
        do_reset();
        cyc();

        // Single uncontended SPI write
        spi_push(6'h23, 8'h80);
        cyc();
        spi_wr_en = 1'b0;
        chk("t1_level", fifo_level, 1);
        chk("t1_no_bypass", wr_en, 1'b0);
        cyc();
        chk("t1_wr_en", wr_en, 1'b1);
        chk("t1_addr", reg_addr, 6'h23);
        chk("t1_value", reg_value, 8'h80);
        chk("t1_aux_gnt", aux_gnt, 1'b0);
        chk("t1_level0", fifo_level, 0);
        cyc();

        // Aux handshake with a back-to-back second request
        aux_req = 1'b1; aux_addr = 6'h1B; aux_value = 8'h10;
        cyc();
        chk("t2_wr_en", wr_en, 1'b1);
        chk("t2_gnt", aux_gnt, 1'b1);
        chk("t2_addr", reg_addr, 6'h1B);
        aux_addr = 6'h1C; aux_value = 8'h20;
        cyc();
        chk("t2_gnt2", aux_gnt, 1'b1);
        chk("t2_addr2", reg_addr, 6'h1C);
        aux_req = 1'b0;
        cyc();
        chk("t2_done", wr_en, 1'b0);

        // Full FIFO: push and SPI pop together keep level at DEPTH
        spi_push(6'h01, 8'h01);              // leaves SPI as last served
        cyc();
        spi_wr_en = 1'b0;
        cyc();
        cyc();
        spi_push(6'h0A, 8'hA0);
        cyc();
        aux_req = 1'b1; aux_addr = 6'h2A; aux_value = 8'h33;
        spi_push(6'h0B, 8'hB0);
        cyc();
        chk("t5_full", fifo_level, DEPTH);
        chk("t5_aux_first", aux_gnt, 1'b1);
        aux_req = 1'b0;
        spi_push(6'h0C, 8'hC0);
        cyc();
        spi_wr_en = 1'b0;
        chk("t5_level_kept", fifo_level, DEPTH);
        chk("t5_no_ovf", ovf, 1'b0);
        chk("t5_pop_addr", reg_addr, 6'h0A);

        // Reset mid-operation with a full FIFO and a pending aux request
        aux_req = 1'b1; aux_addr = 6'h3F; aux_value = 8'hEE;
        do_reset();
        cyc();
        chk("t6_no_stale", wr_en, 1'b0);
        cyc();
        chk("t6_no_stale2", wr_en, 1'b0);

        // Tie from reset goes to SPI, then grants alternate
        spi_push(6'h05, 8'h11);
        cyc();
        spi_wr_en = 1'b0;
        aux_req = 1'b1; aux_addr = 6'h06; aux_value = 8'h22;
        cyc();
        chk("t3_spi_first", reg_addr, 6'h05);
        chk("t3_spi_gnt", aux_gnt, 1'b0);
        cyc();
        chk("t3_aux_next", reg_addr, 6'h06);
        chk("t3_aux_gnt", aux_gnt, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (aux_gnt) begin aux_addr = 6'(8 + i); aux_value = 8'(i); end
            spi_push(6'(16 + i), 8'(i * 3));
            cyc();
            chk("t3_alt", aux_gnt, (i % 2) == 0);
        end
        drain();

        // Overflow under sustained aux pressure, then clear
        aux_req = 1'b1; aux_addr = 6'h30; aux_value = 8'h01;
        for (int i = 0; i < 5; i++) begin
            spi_push(6'(32 + i), 8'(64 + i));
            cyc();
            if (aux_gnt) begin aux_addr = 6'(48 + i); aux_value = 8'(i); end
        end
        spi_wr_en = 1'b0;
        chk("t4_ovf_set", ovf, 1'b1);
        aux_req = 1'b0;
        ovf_clr = 1'b1;
        cyc();
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", ovf, 1'b0);
        drain();

        // Randomised traffic with a well-behaved aux requester
        for (int n = 0; n < 2000; n++) begin
            spi_wr_en = ($urandom_range(2, 0) == 0);
            spi_addr  = 6'($urandom);
            spi_value = 8'($urandom);
            ovf_clr   = ($urandom_range(15, 0) == 0);
            if (aux_req && aux_gnt) begin
                aux_req = ($urandom_range(3, 0) != 0);
                aux_addr = 6'($urandom); aux_value = 8'($urandom);
            end else if (aux_req) begin
                if ($urandom_range(7, 0) == 0) aux_req = 1'b0;
            end else if ($urandom_range(2, 0) == 0) begin
                aux_req = 1'b1;
                aux_addr = 6'($urandom); aux_value = 8'($urandom);
            end
            cyc();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
